proc_net_interface: RTL and testbench

Processor-side network interface sitting directly downstream of the MIPS decode/control stage and upstream of the local NoC router port. It accepts ALU results flagged by the `ni_out` instruction, packs them into single-flit packets and queues them toward the router. In the other direction it buffers flits arriving from the router and presents their payloads to the processor for the `ni_in` instruction. Both directions are decoupled by independent FIFOs with valid/ready handshakes.

---
 rtl/ni_pkg.sv | 29 ++
 rtl/ni_fifo.sv | 44 ++++
 rtl/proc_net_interface.sv | 94 +++++++++
 tb/tb_proc_net_interface.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ni_pkg.sv
// ni_pkg: flit layout constants plus pack/extract helpers for the processor network interface.
package ni_pkg;
   localparam int NI_DATA_W   = 32;
   localparam int NI_ADDR_W   = 2;
   localparam int FLIT_W      = NI_DATA_W + 2 * NI_ADDR_W;
   localparam int PAYLOAD_LSB = 0;
   localparam int SRC_LSB     = NI_DATA_W;
   localparam int DEST_LSB    = NI_DATA_W + NI_ADDR_W;

   typedef logic [FLIT_W-1:0]    flit_t;
   typedef logic [NI_ADDR_W-1:0] addr_t;
   typedef logic [NI_DATA_W-1:0] data_t;

   function automatic flit_t pack_flit(input addr_t dest, input addr_t src, input data_t payload);
      return {dest, src, payload};
   endfunction

   function automatic addr_t get_dest(input flit_t f);
      return f[DEST_LSB +: NI_ADDR_W];
   endfunction

   function automatic addr_t get_src(input flit_t f);
      return f[SRC_LSB +: NI_ADDR_W];
   endfunction

   function automatic data_t get_payload(input flit_t f);
      return f[PAYLOAD_LSB +: NI_DATA_W];
   endfunction
endpackage

// File: rtl/ni_fifo.sv
// ni_fifo: first-word fall-through FIFO with registered storage; head reads as zero while empty.
module ni_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          wr, rd;

   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign dout  = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr) - CW'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/proc_net_interface.sv
// proc_net_interface: packs ni_out words into flits toward the router and buffers router flits for ni_in.
// Define NI_DEST_CHECK_EN to drop and count received flits not addressed to NODE_ID.
module proc_net_interface
   import ni_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 2,
   parameter int NODE_ID    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       proc_valid,
   input  logic [DATA_W-1:0]          proc_data,
   input  logic [ADDR_W-1:0]          dest_add,
   output logic                       mips_ni,
   input  logic                       proc_ready_in,
   input  logic                       reg_en,
   output logic                       data_valid,
   output logic [DATA_W-1:0]          data_out,
   output logic [ADDR_W-1:0]          src_out,
   output logic                       flit_out_valid,
   output logic [DATA_W+2*ADDR_W-1:0] flit_out,
   input  logic                       flit_out_ready,
   input  logic                       flit_in_valid,
   input  logic [DATA_W+2*ADDR_W-1:0] flit_in,
   output logic                       flit_in_ready,
   output logic [7:0]                 drop_cnt
);
   localparam int FW = DATA_W + 2 * ADDR_W;

   // The package helpers are fixed-width, so the flit geometry must match them.
   if (DATA_W != NI_DATA_W || ADDR_W != NI_ADDR_W) begin : g_width_check
      $error("proc_net_interface: DATA_W/ADDR_W must match ni_pkg");
   end

   logic                         tx_full, tx_empty, rx_full, rx_empty;
   logic                         rx_accept, rx_push;
   logic [$clog2(FIFO_DEPTH):0]  tx_count, rx_count;
   logic [ADDR_W+DATA_W-1:0]     rx_head;

   assign mips_ni        = !tx_full;
   assign flit_out_valid = !tx_empty;
   assign flit_in_ready  = !rx_full;
   assign data_valid     = !rx_empty;
   assign rx_accept      = flit_in_valid && flit_in_ready;
   assign src_out        = rx_head[DATA_W +: ADDR_W];
   assign data_out       = rx_head[DATA_W-1:0];

   ni_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (proc_valid && mips_ni),
      .pop   (flit_out_ready),
      .din   (pack_flit(dest_add, ADDR_W'(NODE_ID), proc_data)),
      .dout  (flit_out),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   // RX keeps only source and payload; the destination has served its purpose at the filter.
   ni_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .pop   (proc_ready_in && reg_en),
      .din   ({get_src(flit_in), get_payload(flit_in)}),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

`ifdef NI_DEST_CHECK_EN
   logic dest_ok;
   logic unused_counts;

   assign dest_ok       = get_dest(flit_in) == ADDR_W'(NODE_ID);
   assign rx_push       = rx_accept && dest_ok;
   assign unused_counts = ^{tx_count, rx_count};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt <= '0;
      else if (rx_accept && !dest_ok && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`else
   logic unused_counts;

   assign rx_push       = rx_accept;
   assign drop_cnt      = '0;
   assign unused_counts = ^{tx_count, rx_count, get_dest(flit_in)};
`endif
endmodule

// File: tb/tb_proc_net_interface.sv
// tb_proc_net_interface: directed stimulus with queue scoreboards checked by a negedge monitor.
module tb_proc_net_interface;
   logic        clk = 0;
   logic        rst_n = 1;
   logic        proc_valid = 0, proc_ready_in = 0, reg_en = 0;
   logic [31:0] proc_data = '0;
   logic [1:0]  dest_add = '0;
   logic        mips_ni, data_valid, flit_out_valid, flit_in_ready;
   logic [31:0] data_out;
   logic [1:0]  src_out;
   logic [35:0] flit_out;
   logic        flit_out_ready = 0, flit_in_valid = 0;
   logic [35:0] flit_in = '0;
   logic [7:0]  drop_cnt;

   int checks = 0, errors = 0;
   logic [35:0] tx_q[$];
   logic [33:0] rx_q[$];

   logic [35:0] rx_f [8] = '{36'h4_A0000000, 36'h5_B0000001, 36'h6_C0000002, 36'h7_D0000003,
                              36'h4_E0000004, 36'h5_F0000005, 36'h6_12000006, 36'h7_34000007};
   logic [33:0] rx_e [8] = '{34'h0_A0000000, 34'h1_B0000001, 34'h2_C0000002, 34'h3_D0000003,
                              34'h0_E0000004, 34'h1_F0000005, 34'h2_12000006, 34'h3_34000007};

   always #5 clk = ~clk;

   proc_net_interface #(.DATA_W(32), .ADDR_W(2), .NODE_ID(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .proc_valid(proc_valid), .proc_data(proc_data), .dest_add(dest_add),
      .mips_ni(mips_ni), .proc_ready_in(proc_ready_in), .reg_en(reg_en), .data_valid(data_valid),
      .data_out(data_out), .src_out(src_out), .flit_out_valid(flit_out_valid), .flit_out(flit_out),
      .flit_out_ready(flit_out_ready), .flit_in_valid(flit_in_valid), .flit_in(flit_in),
      .flit_in_ready(flit_in_ready), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tx_send(input logic [1:0] d, input logic [31:0] p, input logic [35:0] exp, input bit acc);
      proc_valid = 1;
      dest_add   = d;
      proc_data  = p;
      chk("mips_ni_before_push", mips_ni, acc);
      if (acc) tx_q.push_back(exp);
      tick();
      proc_valid = 0;
   endtask

   // Handshakes complete on the next rising edge; sampling at the falling edge sees them settled.
   always @(negedge clk) begin
      if (rst_n && flit_out_valid && flit_out_ready) begin
         if (tx_q.size() == 0) chk("tx_unexpected_flit", flit_out, 36'h0);
         else chk("tx_flit", flit_out, tx_q.pop_front());
      end
      if (rst_n && data_valid && proc_ready_in && reg_en) begin
         if (rx_q.size() == 0) chk("rx_unexpected_word", {src_out, data_out}, 34'h0);
         else chk("rx_word", {src_out, data_out}, rx_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 0;
      #2;
      chk("rst_mips_ni", mips_ni, 1);
      chk("rst_flit_in_ready", flit_in_ready, 1);
      chk("rst_flit_out_valid", flit_out_valid, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_flit_out", flit_out, 0);
      tick();
      tick();
      rst_n = 1;
      tick();

      tx_send(2'd2, 32'hDEADBEEF, 36'h9_DEADBEEF, 1);
      chk("t1_flit_out_valid", flit_out_valid, 1);
      chk("t1_flit_out", flit_out, 36'h9_DEADBEEF);
      flit_out_ready = 1;
      tick();
      flit_out_ready = 0;
      chk("t1_drained", tx_q.size(), 0);
      chk("t1_valid_low", flit_out_valid, 0);

      tx_send(2'd0, 32'h11111111, 36'h1_11111111, 1);
      tx_send(2'd1, 32'h22222222, 36'h5_22222222, 1);
      tx_send(2'd2, 32'h33333333, 36'h9_33333333, 1);
      tx_send(2'd3, 32'h44444444, 36'hD_44444444, 1);
      chk("t2_full_mips_ni", mips_ni, 0);
      tx_send(2'd1, 32'h55555555, 36'h5_55555555, 0);
      flit_out_ready = 1;
      repeat (4) tick();
      chk("t2_drain_4_cycles", flit_out_valid, 0);
      chk("t2_queue_empty", tx_q.size(), 0);
      chk("t2_mips_ni_back", mips_ni, 1);
      flit_out_ready = 0;

      flit_in_valid = 1;
      flit_in = 36'h7_12345678;
      chk("t3_flit_in_ready", flit_in_ready, 1);
      rx_q.push_back(34'h3_12345678);
      tick();
      flit_in_valid = 0;
      chk("t3_data_valid", data_valid, 1);
      chk("t3_data_out", data_out, 32'h12345678);
      chk("t3_src_out", src_out, 3);
      proc_ready_in = 1;
      reg_en = 1;
      tick();
      reg_en = 0;
      chk("t3_data_valid_low", data_valid, 0);
      chk("t3_rx_consumed", rx_q.size(), 0);

      for (int i = 0; i < 4; i++) begin
         flit_in_valid = 1;
         flit_in = rx_f[i];
         chk("t4_ready_filling", flit_in_ready, 1);
         rx_q.push_back(rx_e[i]);
         tick();
      end
      flit_in_valid = 0;
      chk("t4_full_ready_low", flit_in_ready, 0);
      chk("t4_count_full", dut.u_rx.count, 4);
      reg_en = 1;
      tick();
      for (int i = 4; i < 8; i++) begin
         flit_in_valid = 1;
         flit_in = rx_f[i];
         chk("t4_ready_streaming", flit_in_ready, 1);
         rx_q.push_back(rx_e[i]);
         tick();
         chk("t4_count_steady", dut.u_rx.count, 3);
      end
      flit_in_valid = 0;
      repeat (3) tick();
      reg_en = 0;
      chk("t4_rx_empty", data_valid, 0);
      chk("t4_rx_consumed", rx_q.size(), 0);

`ifdef NI_DEST_CHECK_EN
      flit_in_valid = 1;
      flit_in = 36'h2_55AA55AA;
      tick();
      chk("t5_dropped_not_valid", data_valid, 0);
      chk("t5_drop_cnt_1", drop_cnt, 1);
      repeat (299) tick();
      flit_in_valid = 0;
      chk("t5_drop_cnt_sat", drop_cnt, 255);
      chk("t5_still_empty", data_valid, 0);
`else
      flit_in_valid = 1;
      flit_in = 36'h2_55AA55AA;
      rx_q.push_back(34'h2_55AA55AA);
      tick();
      flit_in_valid = 0;
      chk("t5_enqueued_any_dest", data_valid, 1);
      chk("t5_drop_cnt_zero", drop_cnt, 0);
      reg_en = 1;
      tick();
      reg_en = 0;
      chk("t5_rx_consumed", rx_q.size(), 0);
`endif

      tx_send(2'd3, 32'h000000A1, 36'hD_000000A1, 1);
      tx_send(2'd0, 32'h000000B2, 36'h1_000000B2, 1);
      tx_send(2'd2, 32'h000000C3, 36'h9_000000C3, 1);
      flit_in_valid = 1;
      flit_in = 36'h5_0000AAAA;
      rx_q.push_back(34'h1_0000AAAA);
      tick();
      flit_in = 36'h6_0000BBBB;
      rx_q.push_back(34'h2_0000BBBB);
      tick();
      flit_in_valid = 0;
      flit_out_ready = 1;
      reg_en = 1;
      tick();
      #1 rst_n = 0;
      tx_q.delete();
      rx_q.delete();
      flit_out_ready = 0;
      reg_en = 0;
      #1;
      chk("t6_mips_ni", mips_ni, 1);
      chk("t6_flit_in_ready", flit_in_ready, 1);
      chk("t6_flit_out_valid", flit_out_valid, 0);
      chk("t6_data_valid", data_valid, 0);
      chk("t6_drop_cnt", drop_cnt, 0);
      chk("t6_data_out", data_out, 0);
      chk("t6_src_out", src_out, 0);
      chk("t6_flit_out", flit_out, 0);
      tick();
      rst_n = 1;
      tick();
      chk("t6_tx_discarded", flit_out_valid, 0);
      chk("t6_rx_discarded", data_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
